fp_align_add: RTL
=================

FP_ALIGN_ADD -- requirements
Module: fp_align_add

Interface
REQ-001 SHALL have no parameters; widths SHALL come from float_pkg: EXPONENT_BITS (8), FRACTION_BITS (23), type float {sign, exponent, fraction}.
REQ-002 SHALL use one clock and an asynchronous, active-low reset.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 bign  input  float  larger-magnitude operand, from the upstream fp_sorter stage.
REQ-006 smalln  input  float  smaller-magnitude operand; |smalln| <= |bign| is guaranteed by upstream.
REQ-007 in_valid  input  1  operands valid.
REQ-008 in_ready  output  1  block can accept operands.
REQ-009 result  output  float  bign + smalln.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts result.

Function
REQ-012 FSM states SHALL be IDLE, ALIGN, ADD, NORM, DONE.
REQ-013 IDLE: in_ready=1, other outputs 0. On in_valid at a clock edge, bign and smalln SHALL be registered and the FSM SHALL go to ALIGN.
REQ-014 In every state other than IDLE, in_ready SHALL be 0, and in_valid SHALL be ignored.
REQ-015 Mantissa SHALL be {hidden, fraction} (24 b).
- hidden=1 if exponent!=0.
- An operand with exponent==0 SHALL be treated as zero (mantissa 0; denormals flushed).
REQ-016 ALIGN (1 cycle): d = big.exponent - small.exponent (unsigned).
- Small mantissa SHALL be shifted right by d in a single cycle.
- If d>=24, the small mantissa SHALL be 0.
- Shifted-out bits SHALL be discarded (truncation, no rounding).
- Next state SHALL be ADD.
REQ-017 ADD (1 cycle): 25-bit sum.
- If signs are equal, sum = big_m + small_m.
- If signs differ, sum = big_m - small_m.
- res_exp = big.exponent; res_sign = big.sign.
REQ-018 ADD zero result: if sum==0, result SHALL be +0 (0x00000000) and the next state SHALL be DONE.
REQ-019 ADD carry: if sum[24]=1, sum SHALL shift right 1 and res_exp SHALL increment by 1.
- If the incremented exponent equals 255, result SHALL be {res_sign, 8'hFF, 0} (infinity) and the next state SHALL be DONE.
REQ-020 ADD otherwise: next state SHALL be NORM.
REQ-021 NORM: each cycle where sum[23]=0, sum SHALL shift left 1 and res_exp SHALL decrement by 1.
- If res_exp reaches 0 before sum[23]=1, result SHALL be {res_sign, 0, 0} (flush to zero) and the next state SHALL be DONE.
REQ-022 NORM exit: on the cycle sum[23]=1, result SHALL be {res_sign, res_exp, sum[22:0]} and the next state SHALL be DONE.
REQ-023 Latency: with n NORM left shifts, out_valid SHALL rise 4+n clock edges after the accepting edge.
- NORM always takes at least 1 cycle on the non-zero, non-overflow path.
- Zero and overflow results SHALL rise after exactly 3 edges.
REQ-024 DONE: out_valid=1 and result SHALL be held stable until out_ready=1 at a clock edge; then the FSM SHALL return to IDLE.
- The earliest next accept is the following cycle; there is no same-cycle accept.
REQ-025 out_valid SHALL never deassert without a completed out_ready handshake, except on reset.
REQ-026 result SHALL be 0 whenever out_valid=0.
REQ-027 Inputs with exponent 255 (inf/NaN) are outside the supported operand range; their behaviour is unspecified but SHALL NOT hang the FSM.

Reset
REQ-028 rst_n low SHALL, asynchronously and in any state, force state=IDLE, result=0, out_valid=0, in_ready=1, and clear all internal registers.
REQ-029 An operation in progress when reset asserts SHALL be discarded; no out_valid SHALL follow reset release without a new accept.

Verification
REQ-030 0x3F800000 + 0x3F800000 (1+1) -> result 0x40000000, out_valid 4 edges after accept.
REQ-031 0x3FC00000 + 0xBF800000 (1.5-1) -> 0x3F000000 (0.5), n=1, latency 5.
REQ-032 0x3F800000 + 0xBF800000 -> 0x00000000 at latency 3; 0x4E800000 + 0x3F800000 (d=30) -> 0x4E800000.
REQ-033 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000 at latency 3.
REQ-034 Hold out_ready=0 for 5 cycles in DONE -> result and out_valid stable, in_ready=0, a new in_valid is ignored; after out_ready=1, IDLE and in_ready=1.
REQ-035 Pulse rst_n low during NORM (0x3F800001 + 0xBF800000) -> outputs reset immediately, no out_valid follows; a next 1+1 operation completes correctly.

Source files
------------

// File: rtl/fp_align_add.sv
// -----------------------------------------------------------------------------
// fp_align_add
// Multi-cycle single-precision adder stage (align / add / normalise). Takes a
// pre-sorted operand pair (|smalln| <= |bign|) and produces bign + smalln.
// Denormal inputs are flushed to zero, alignment shifts truncate, and an
// exponent underflow during normalisation flushes the result to signed zero.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   bign       in   larger-magnitude operand (float)
//   smalln     in   smaller-magnitude operand (float)
//   in_valid   in   operand pair valid
//   in_ready   out  block idle and able to accept operands
//   result     out  sum, zero whenever out_valid is low
//   out_valid  out  result valid, held until out_ready handshake
//   out_ready  in   consumer accepts result
// -----------------------------------------------------------------------------

package float_pkg;
    localparam int EXPONENT_BITS = 8;
    localparam int FRACTION_BITS = 23;

    typedef struct packed {
        logic                     sign;
        logic [EXPONENT_BITS-1:0] exponent;
        logic [FRACTION_BITS-1:0] fraction;
    } float;
endpackage

module fp_align_add
    import float_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  float bign,
    input  float smalln,
    input  logic in_valid,
    output logic in_ready,
    output float result,
    output logic out_valid,
    input  logic out_ready
);

    localparam int MW = FRACTION_BITS + 1;   // mantissa width incl. hidden bit

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        ADD   = 3'd2,
        NORM  = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Mantissa with hidden bit; zero exponent flushes the operand to zero.
    function automatic logic [MW-1:0] mantissa(input float f);
        if (f.exponent != {EXPONENT_BITS{1'b0}}) begin
            mantissa = {1'b1, f.fraction};
        end else begin
            mantissa = {MW{1'b0}};
        end
    endfunction

    state_t                   r_state;
    float                     r_big;
    float                     r_small;
    logic [MW-1:0]            r_big_m;
    logic [MW-1:0]            r_small_m;
    logic [MW:0]              r_sum;
    logic [EXPONENT_BITS-1:0] r_res_exp;
    float                     r_pending;
    float                     r_result;
    logic                     r_out_valid;
    logic                     r_in_ready;

    logic [EXPONENT_BITS-1:0] w_diff;
    logic [MW-1:0]            w_small_m;
    logic [MW-1:0]            w_small_aligned;
    logic [MW:0]              w_sum;
    logic [EXPONENT_BITS:0]   w_exp_inc;

    // Datapath for the ALIGN and ADD stages.
    always_comb begin
        w_diff          = r_big.exponent - r_small.exponent;
        w_small_m       = mantissa(r_small);
        w_small_aligned = {MW{1'b0}};
        if (w_diff >= 8'd24) begin
            w_small_aligned = {MW{1'b0}};
        end else begin
            w_small_aligned = w_small_m >> w_diff;
        end
        if (r_big.sign == r_small.sign) begin
            w_sum = {1'b0, r_big_m} + {1'b0, r_small_m};
        end else begin
            w_sum = {1'b0, r_big_m} - {1'b0, r_small_m};
        end
        w_exp_inc = {1'b0, r_big.exponent} + 9'd1;
    end

    // Control FSM and all state/output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_big       <= '0;
            r_small     <= '0;
            r_big_m     <= {MW{1'b0}};
            r_small_m   <= {MW{1'b0}};
            r_sum       <= {(MW+1){1'b0}};
            r_res_exp   <= {EXPONENT_BITS{1'b0}};
            r_pending   <= '0;
            r_result    <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_big      <= bign;
                        r_small    <= smalln;
                        r_in_ready <= 1'b0;
                        r_state    <= ALIGN;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                ALIGN: begin
                    r_big_m   <= mantissa(r_big);
                    r_small_m <= w_small_aligned;
                    r_state   <= ADD;
                end
                ADD: begin
                    if (w_sum == {(MW+1){1'b0}}) begin
                        r_pending <= '0;
                        r_state   <= DONE;
                    end else if (w_sum[MW]) begin
                        // Carry out: renormalise right; saturate to infinity.
                        if (w_exp_inc >= 9'd255) begin
                            r_pending <= {r_big.sign, 8'hFF, 23'd0};
                            r_state   <= DONE;
                        end else begin
                            r_sum     <= w_sum >> 1;
                            r_res_exp <= w_exp_inc[EXPONENT_BITS-1:0];
                            r_state   <= NORM;
                        end
                    end else begin
                        r_sum     <= w_sum;
                        r_res_exp <= r_big.exponent;
                        r_state   <= NORM;
                    end
                end
                NORM: begin
                    if (r_sum[MW-1]) begin
                        r_pending <= {r_big.sign, r_res_exp, r_sum[MW-2:0]};
                        r_state   <= DONE;
                    end else if (r_res_exp <= 8'd1) begin
                        // Another left shift would underflow the exponent.
                        r_pending <= {r_big.sign, 8'd0, 23'd0};
                        r_state   <= DONE;
                    end else begin
                        r_sum     <= r_sum << 1;
                        r_res_exp <= r_res_exp - 8'd1;
                    end
                end
                DONE: begin
                    // First DONE cycle presents the result; then wait for handshake.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_result    <= r_pending;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_result    <= '0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end else begin
                        r_out_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_result    <= '0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;

endmodule
